// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types for the data-memory access controller.
// Optional perf counter is enabled with DMEM_CTRL_PERF_EN.
package dmem_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_t;
   localparam owner_t LAST_GRANT_RST = OWN_DBG;
endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: requester ports (cpu, dbg) and memory bus.
// slave = controller side, master = requesters + memory side.
interface dmem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req_i;
   logic              cpu_we_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [DATA_W-1:0] cpu_wdata_i;
   logic [DATA_W-1:0] cpu_rdata_o;
   logic              cpu_stall_o;
   logic              dbg_req_i;
   logic              dbg_we_i;
   logic [ADDR_W-1:0] dbg_addr_i;
   logic [DATA_W-1:0] dbg_wdata_i;
   logic [DATA_W-1:0] dbg_rdata_o;
   logic              dbg_ack_o;
   logic              mem_en_o;
   logic              mem_we_o;
   logic [ADDR_W-3:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      output cpu_rdata_o, cpu_stall_o,
      input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      output dbg_rdata_o, dbg_ack_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      input  cpu_rdata_o, cpu_stall_o,
      output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      input  dbg_rdata_o, dbg_ack_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/dmem_rr_arb.sv
// dmem_rr_arb: 2-way round-robin arbiter, bit0 = CPU, bit1 = DBG.
module dmem_rr_arb
   import dmem_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       enable_i,
   output logic [1:0] grant_o,
   output owner_t     last_grant_o
);
   owner_t last_q, last_d;

   always_comb begin
      grant_o = 2'b00;
      if (enable_i) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == OWN_DBG) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_d = last_q;
      if (grant_o[0]) last_d = OWN_CPU;
      else if (grant_o[1]) last_d = OWN_DBG;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) last_q <= LAST_GRANT_RST;
      else        last_q <= last_d;
   end

   assign last_grant_o = last_q;
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences cpu/dbg accesses to a fixed-latency dmem.
// Define DMEM_CTRL_PERF_EN to add the perf_stall_cnt_o counter.
module dmem_access_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
`ifdef DMEM_CTRL_PERF_EN
   output logic [31:0] perf_stall_cnt_o,
`endif
   dmem_access_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-3:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   crd_q, crd_d;
   logic [DATA_W-1:0]   drd_q, drd_d;
   logic [1:0]          grant;
   owner_t              owner;
   logic                stall;
   logic                unused_addr_lsbs;

   assign unused_addr_lsbs = ^{bus.cpu_addr_i[1:0], bus.dbg_addr_i[1:0]};

   // last_grant only moves on a grant, so it names the in-flight owner
   dmem_rr_arb u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       ({bus.dbg_req_i, bus.cpu_req_i}),
      .enable_i    (state_q == IDLE && start_i),
      .grant_o     (grant),
      .last_grant_o(owner)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      crd_d   = crd_q;
      drd_d   = drd_q;
      case (state_q)
         IDLE: begin
            unique case (1'b1)
               grant[1]: begin
                  we_d    = bus.dbg_we_i;
                  addr_d  = bus.dbg_addr_i[ADDR_W-1:2];
                  wdata_d = bus.dbg_wdata_i;
                  cnt_d   = CNT_LOAD;
                  state_d = BUSY;
               end
               grant[0]: begin
                  we_d    = bus.cpu_we_i;
                  addr_d  = bus.cpu_addr_i[ADDR_W-1:2];
                  wdata_d = bus.cpu_wdata_i;
                  cnt_d   = CNT_LOAD;
                  state_d = BUSY;
               end
               default: ;
            endcase
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               if (!we_q) begin
                  if (owner == OWN_DBG) drd_d = bus.mem_rdata_i;
                  else                  crd_d = bus.mem_rdata_i;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         crd_q   <= '0;
         drd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         crd_q   <= crd_d;
         drd_q   <= drd_d;
      end
   end

   assign stall = bus.cpu_req_i &&
                  !(state_q == RESP && owner == OWN_CPU);

   assign bus.cpu_stall_o = stall;
   assign bus.cpu_rdata_o = crd_q;
   assign bus.dbg_rdata_o = drd_q;
   assign bus.dbg_ack_o   = (state_q == RESP) && (owner == OWN_DBG);
   assign bus.mem_en_o    = (state_q == BUSY) && (cnt_q == CNT_LOAD);
   assign bus.mem_we_o    = (state_q == BUSY) && we_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;

`ifdef DMEM_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (stall && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign perf_stall_cnt_o = perf_q;
`endif
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: transaction-level model of arbitration, latency
// and memory contents, checked against the controller each cycle.
module tb_dmem_access_ctrl;
   localparam int LAT = 2;

   logic clk;
   logic rst_n;
   logic start;
`ifdef DMEM_CTRL_PERF_EN
   logic [31:0] perf;
`endif

   dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) dut (
      .clk_i           (clk),
      .rst_i           (rst_n),
      .start_i         (start),
`ifdef DMEM_CTRL_PERF_EN
      .perf_stall_cnt_o(perf),
`endif
      .bus             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: write on strobe, read data valid only in last busy cycle
   logic [31:0] mem [16];
   int          age;
   logic        rd_valid;

   initial age = 0;

   always @(posedge clk) begin
      if (bus.mem_en_o) begin
         age <= 1;
         if (bus.mem_we_o) mem[bus.mem_addr_o[3:0]] <= bus.mem_wdata_o;
      end else if (age != 0 && age < LAT - 1) begin
         age <= age + 1;
      end else begin
         age <= 0;
      end
   end

   assign rd_valid = (LAT == 1) ? bus.mem_en_o : (age == LAT - 1);
   assign bus.mem_rdata_i = rd_valid ? mem[bus.mem_addr_o[3:0]]
                                     : 32'hBAD0_0BAD;

   int          vectors;
   int          miscompares;
   bit          exp_last_dbg;
   logic [31:0] exp_crd;
   logic [31:0] exp_drd;
   logic [31:0] ref_mem [16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_reqs();
      bus.cpu_req_i = 1'b0;
      bus.dbg_req_i = 1'b0;
      tick();
   endtask

   task automatic model_reset();
      exp_last_dbg = 1'b1;
      exp_crd      = '0;
      exp_drd      = '0;
   endtask

   // one arbitrated transaction, starting in an IDLE cycle
   task automatic run_round(
      input bit c_on, input bit c_we,
      input logic [31:0] c_addr, input logic [31:0] c_wd,
      input bit d_on, input bit d_we,
      input logic [31:0] d_addr, input logic [31:0] d_wd,
      input string tag);
      bit          win_dbg;
      bit          w_we;
      logic [31:0] w_addr;
      logic [31:0] w_wd;
      int          idx;
      win_dbg = d_on && (!c_on || !exp_last_dbg);
      exp_last_dbg = win_dbg;
      w_we   = win_dbg ? d_we : c_we;
      w_addr = win_dbg ? d_addr : c_addr;
      w_wd   = win_dbg ? d_wd : c_wd;
      idx    = int'(w_addr[5:2]);
      bus.cpu_req_i = c_on; bus.cpu_we_i = c_we;
      bus.cpu_addr_i = c_addr; bus.cpu_wdata_i = c_wd;
      bus.dbg_req_i = d_on; bus.dbg_we_i = d_we;
      bus.dbg_addr_i = d_addr; bus.dbg_wdata_i = d_wd;
      #1;
      vectors++;
      if (bus.cpu_stall_o !== c_on) begin
         miscompares++;
         $display("FAIL %s/idle_stall: got %b want %b",
                  tag, bus.cpu_stall_o, c_on);
      end
      tick();
      vectors++;
      if (bus.mem_en_o !== 1'b1 || bus.mem_we_o !== w_we ||
          bus.mem_addr_o !== w_addr[31:2] ||
          bus.mem_wdata_o !== w_wd) begin
         miscompares++;
         $display("FAIL %s/strobe: got en=%b we=%b a=%0h d=%0h want en=1 we=%b a=%0h d=%0h",
                  tag, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o,
                  bus.mem_wdata_o, w_we, w_addr[31:2], w_wd);
      end
      vectors++;
      if (bus.cpu_stall_o !== c_on || bus.dbg_ack_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s/busy1: got stall=%b ack=%b want stall=%b ack=0",
                  tag, bus.cpu_stall_o, bus.dbg_ack_o, c_on);
      end
      for (int k = 2; k <= LAT; k++) begin
         tick();
         vectors++;
         if (bus.mem_en_o !== 1'b0 || bus.mem_we_o !== w_we ||
             bus.cpu_stall_o !== c_on || bus.dbg_ack_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s/busy%0d: got en=%b we=%b stall=%b ack=%b want en=0 we=%b stall=%b ack=0",
                     tag, k, bus.mem_en_o, bus.mem_we_o,
                     bus.cpu_stall_o, bus.dbg_ack_o, w_we, c_on);
         end
      end
      tick();
      if (!w_we && win_dbg)  exp_drd = ref_mem[idx];
      if (!w_we && !win_dbg) exp_crd = ref_mem[idx];
      if (w_we) ref_mem[idx] = w_wd;
      vectors++;
      if (bus.dbg_ack_o !== win_dbg ||
          bus.cpu_stall_o !== (c_on && win_dbg) ||
          bus.mem_en_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s/resp: got ack=%b stall=%b en=%b we=%b want ack=%b stall=%b en=0 we=0",
                  tag, bus.dbg_ack_o, bus.cpu_stall_o, bus.mem_en_o,
                  bus.mem_we_o, win_dbg, c_on && win_dbg);
      end
      vectors++;
      if (bus.cpu_rdata_o !== exp_crd || bus.dbg_rdata_o !== exp_drd) begin
         miscompares++;
         $display("FAIL %s/rdata: got cpu=%0h dbg=%0h want cpu=%0h dbg=%0h",
                  tag, bus.cpu_rdata_o, bus.dbg_rdata_o, exp_crd, exp_drd);
      end
      tick();
      vectors++;
      if (mem[idx] !== ref_mem[idx]) begin
         miscompares++;
         $display("FAIL %s/mem[%0d]: got %0h want %0h",
                  tag, idx, mem[idx], ref_mem[idx]);
      end
   endtask

   task automatic test_reset();
      bus.cpu_req_i = 0; bus.cpu_we_i = 0;
      bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
      bus.dbg_req_i = 0; bus.dbg_we_i = 0;
      bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;
      start = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      model_reset();
      #1;
      vectors++;
      if (bus.mem_en_o !== 0 || bus.mem_we_o !== 0 || bus.dbg_ack_o !== 0 ||
          bus.mem_addr_o !== '0 || bus.mem_wdata_o !== '0 ||
          bus.cpu_rdata_o !== '0 || bus.dbg_rdata_o !== '0 ||
          bus.cpu_stall_o !== 0) begin
         miscompares++;
         $display("FAIL reset_outputs: got en=%b we=%b ack=%b a=%0h d=%0h crd=%0h drd=%0h stall=%b want all 0",
                  bus.mem_en_o, bus.mem_we_o, bus.dbg_ack_o,
                  bus.mem_addr_o, bus.mem_wdata_o, bus.cpu_rdata_o,
                  bus.dbg_rdata_o, bus.cpu_stall_o);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         vectors++;
         if (bus.mem_en_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_quiet[%0d]: got en=%b stall=%b want 0 0",
                     i, bus.mem_en_o, bus.cpu_stall_o);
         end
      end
   endtask

   task automatic test_dbg_loader();
      for (int i = 0; i < 16; i++) begin
         run_round(0, 0, '0, '0, 1, 1, 32'(i * 4), $urandom, "loader");
      end
      drop_reqs();
   endtask

   task automatic test_cpu_load();
      run_round(0, 0, '0, '0, 1, 1, 32'h08, 32'd5, "preload");
      drop_reqs();
      run_round(1, 0, 32'h08, '0, 0, 0, '0, '0, "cpu_load");
      vectors++;
      if (bus.cpu_rdata_o !== 32'd5) begin
         miscompares++;
         $display("FAIL cpu_load_word2: got %0h want 5", bus.cpu_rdata_o);
      end
      drop_reqs();
   endtask

   task automatic test_cpu_store();
      run_round(1, 1, 32'h0C, 32'h1234, 0, 0, '0, '0, "cpu_store");
      vectors++;
      if (mem[3] !== 32'h1234) begin
         miscompares++;
         $display("FAIL cpu_store_word3: got %0h want 1234", mem[3]);
      end
      drop_reqs();
   endtask

   task automatic test_arbitration();
      rst_n = 1'b0;
      drop_reqs();
      rst_n = 1'b1;
      model_reset();
      for (int r = 0; r < 3; r++) begin
         run_round(1, 0, 32'h04, '0, 1, 0, 32'h24, '0, "arb_held");
      end
      drop_reqs();
   endtask

   task automatic test_start_gate();
      start = 1'b0;
      bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0;
      bus.cpu_addr_i = 32'h10;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (bus.mem_en_o !== 1'b0 || bus.cpu_stall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL start_gate[%0d]: got en=%b stall=%b want en=0 stall=1",
                     i, bus.mem_en_o, bus.cpu_stall_o);
         end
      end
      start = 1'b1;
      run_round(1, 0, 32'h10, '0, 0, 0, '0, '0, "start_raise");
      drop_reqs();
   endtask

   task automatic test_reset_mid();
      bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b0;
      bus.dbg_addr_i = 32'h24;
      tick();
      vectors++;
      if (bus.mem_en_o !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_strobe: got %b want 1", bus.mem_en_o);
      end
      rst_n = 1'b0;
      drop_reqs();
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i <= LAT + 1; i++) begin
         vectors++;
         if (bus.mem_en_o !== 0 || bus.mem_we_o !== 0 ||
             bus.dbg_ack_o !== 0 || bus.cpu_stall_o !== 0 ||
             bus.dbg_rdata_o !== '0 || bus.cpu_rdata_o !== '0) begin
            miscompares++;
            $display("FAIL rst_mid[%0d]: got en=%b we=%b ack=%b stall=%b drd=%0h crd=%0h want all 0",
                     i, bus.mem_en_o, bus.mem_we_o, bus.dbg_ack_o,
                     bus.cpu_stall_o, bus.dbg_rdata_o, bus.cpu_rdata_o);
         end
         tick();
      end
`ifdef DMEM_CTRL_PERF_EN
      vectors++;
      if (perf !== 32'd0) begin
         miscompares++;
         $display("FAIL perf_after_reset: got %0d want 0", perf);
      end
`endif
      run_round(1, 0, 32'h04, '0, 0, 0, '0, '0, "perf_access");
`ifdef DMEM_CTRL_PERF_EN
      vectors++;
      if (perf !== 32'(LAT + 1)) begin
         miscompares++;
         $display("FAIL perf_one_access: got %0d want %0d", perf, LAT + 1);
      end
      $display("Stall count: %0d", perf);
`endif
      drop_reqs();
   endtask

   task automatic test_random();
      bit c_on;
      bit d_on;
      for (int n = 0; n < 40; n++) begin
         c_on = 1'($urandom);
         d_on = 1'($urandom);
         if (!c_on && !d_on) d_on = 1'b1;
         run_round(c_on, 1'($urandom),
                   {26'd0, 1'b0, 3'($urandom), 2'($urandom)}, $urandom,
                   d_on, 1'($urandom),
                   {26'd0, 1'b1, 3'($urandom), 2'($urandom)}, $urandom,
                   "random");
         if ($urandom_range(0, 1) == 0) drop_reqs();
      end
      drop_reqs();
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (mem[i] !== ref_mem[i]) begin
            miscompares++;
            $display("FAIL final_mem[%0d]: got %0h want %0h",
                     i, mem[i], ref_mem[i]);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_dbg_loader();
      test_cpu_load();
      test_cpu_store();
      test_arbitration();
      test_start_gate();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
